// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings and decode helpers for the multi-cycle control FSM
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_BEQ   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_BNE   = 3'b011;
  localparam logic [2:0] ALU_ORI   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  // Where DECODE goes for each opcode; S_FETCH doubles as the "unknown opcode" answer.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:                return S_EXEC_R;
      OP_ADDI, OP_ORI, OP_LUI: return S_EXEC_I;
      OP_LW, OP_SW:            return S_MEM_ADDR;
      OP_BEQ, OP_BNE:          return S_BRANCH;
      OP_J:                    return S_JUMP;
      default:                 return S_FETCH;
    endcase
  endfunction
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    return op == OP_ORI ? ALU_ORI : op == OP_LUI ? ALU_LUI : ALU_ADD;
  endfunction
endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational map from FSM state to every datapath control
module mc_out_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal
);
  // Moore decode, except IR/PC writes in FETCH which wait for the memory
  always_comb begin
    alu_op        = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_src    = PC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SL2;
        illegal   = decode_target(opcode) == S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_op    = ALU_FUNCT;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_aluop(opcode);
      end
      S_WB_I: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
        branch_ne     = opcode == OP_BNE;
        alu_op        = opcode == OP_BNE ? ALU_BNE : ALU_BEQ;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing the multi-cycle MIPS datapath
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic [2:0] ALUOp_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);
  state_t state, next;
  // State register; reset drops straight into RST, even mid-wait
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= S_RST;
    else state <= next;
  // Next-state logic; memory states hold until the ready handshake
  always_comb begin
    next = S_RST;
    case (state)
      S_RST:      next = S_FETCH;
      S_FETCH:    next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:   next = decode_target(opcode_i);
      S_EXEC_R:   next = S_WB_R;
      S_EXEC_I:   next = S_WB_I;
      S_MEM_ADDR: next = opcode_i == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   next = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: next = S_FETCH;
      default:    next = S_RST;
    endcase
  end
  assign state_o = state;
  mc_out_decode u_dec (
    .state        (state),
    .opcode       (opcode_i),
    .mem_ready    (mem_ready_i),
    .alu_op       (ALUOp_o),
    .alu_src_a    (alu_src_a_o),
    .alu_src_b    (alu_src_b_o),
    .pc_src       (pc_src_o),
    .pc_write     (pc_write_o),
    .pc_write_cond(pc_write_cond_o),
    .branch_ne    (branch_ne_o),
    .ir_write     (ir_write_o),
    .mem_read     (mem_read_o),
    .mem_write    (mem_write_o),
    .iord         (iord_o),
    .reg_write    (reg_write_o),
    .reg_dst      (reg_dst_o),
    .mem_to_reg   (mem_to_reg_o),
    .illegal      (illegal_o)
  );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench walking directed instructions through the control FSM
module tb_multicycle_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] opcode_i = 6'h00;
  logic       mem_ready_i = 1'b0;
  logic [2:0] ALUOp_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] pc_src_o;
  logic       pc_write_o, pc_write_cond_o, branch_ne_o;
  logic       ir_write_o, mem_read_o, mem_write_o, iord_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o;
  logic [3:0] state_o;
  // flags order: pw pwc bne irw mr mw iord rw rd m2r ill
  typedef struct packed {
    logic [3:0]  st;
    logic [2:0]  aluop;
    logic        sa;
    logic [1:0]  sb;
    logic [1:0]  ps;
    logic [10:0] f;
  } obs_t;
  obs_t  q_exp[$];
  string q_nm[$];
  int    checks = 0;
  int    failures = 0;
  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .ALUOp_o(ALUOp_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .pc_src_o(pc_src_o), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .branch_ne_o(branch_ne_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .iord_o(iord_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o),
    .state_o(state_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic obs_t ex(input logic [3:0] st, input logic [2:0] a, input logic sa,
                              input logic [1:0] sb, input logic [1:0] ps, input logic [10:0] f);
    return {st, a, sa, sb, ps, f};
  endfunction
  function automatic obs_t e_rst();        return ex(4'd0, 3'b000, 1'b0, 2'b00, 2'b00, 11'b00000000000); endfunction
  function automatic obs_t e_fetch(input logic r);
    return ex(4'd1, 3'b000, 1'b0, 2'b01, 2'b00, r ? 11'b10011000000 : 11'b00001000000);
  endfunction
  function automatic obs_t e_dec(input logic ill);
    return ex(4'd2, 3'b000, 1'b0, 2'b11, 2'b00, {10'b0, ill});
  endfunction
  function automatic obs_t e_exr();        return ex(4'd3, 3'b010, 1'b1, 2'b00, 2'b00, 11'b00000000000); endfunction
  function automatic obs_t e_wbr();        return ex(4'd4, 3'b000, 1'b0, 2'b00, 2'b00, 11'b00000001100); endfunction
  function automatic obs_t e_exi(input logic [2:0] a); return ex(4'd5, a, 1'b1, 2'b10, 2'b00, 11'b00000000000); endfunction
  function automatic obs_t e_wbi();        return ex(4'd6, 3'b000, 1'b0, 2'b00, 2'b00, 11'b00000001000); endfunction
  function automatic obs_t e_madr();       return ex(4'd7, 3'b000, 1'b1, 2'b10, 2'b00, 11'b00000000000); endfunction
  function automatic obs_t e_mrd();        return ex(4'd8, 3'b000, 1'b0, 2'b00, 2'b00, 11'b00001010000); endfunction
  function automatic obs_t e_mwb();        return ex(4'd9, 3'b000, 1'b0, 2'b00, 2'b00, 11'b00000001010); endfunction
  function automatic obs_t e_mwr();        return ex(4'd10, 3'b000, 1'b0, 2'b00, 2'b00, 11'b00000110000); endfunction
  function automatic obs_t e_br(input logic ne);
    return ex(4'd11, ne ? 3'b011 : 3'b001, 1'b1, 2'b00, 2'b01, ne ? 11'b01100000000 : 11'b01000000000);
  endfunction
  function automatic obs_t e_jmp();        return ex(4'd12, 3'b000, 1'b0, 2'b00, 2'b10, 11'b10000000000); endfunction
  // one clock cycle: drive inputs, queue what this cycle must show, advance
  task automatic cyc(input string nm, input logic [5:0] op, input logic rdy, input obs_t e);
    opcode_i = op;
    mem_ready_i = rdy;
    q_exp.push_back(e);
    q_nm.push_back(nm);
    @(posedge clk_i);
    #1;
  endtask
  // monitor: every falling edge is one presented output vector
  always @(negedge clk_i) begin
    obs_t act, exp_v;
    string nm;
    if (q_exp.size() > 0) begin
      act = {state_o, ALUOp_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_write_o, pc_write_cond_o,
             branch_ne_o, ir_write_o, mem_read_o, mem_write_o, iord_o, reg_write_o, reg_dst_o,
             mem_to_reg_o, illegal_o};
      exp_v = q_exp.pop_front();
      nm = q_nm.pop_front();
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL %s: got st=%0d alu=%b sa=%b sb=%b ps=%b f=%b, expected st=%0d alu=%b sa=%b sb=%b ps=%b f=%b",
                 nm, act.st, act.aluop, act.sa, act.sb, act.ps, act.f,
                 exp_v.st, exp_v.aluop, exp_v.sa, exp_v.sb, exp_v.ps, exp_v.f);
      end
    end
  end
  initial begin
    @(posedge clk_i);
    #1;
    cyc("reset_hold", 6'h00, 1'b1, e_rst());
    rst_i = 1'b1;
    cyc("reset_release", 6'h00, 1'b1, e_rst());
    cyc("r_fetch", 6'h00, 1'b1, e_fetch(1'b1));
    cyc("r_decode", 6'h00, 1'b1, e_dec(1'b0));
    cyc("r_exec", 6'h00, 1'b1, e_exr());
    cyc("r_wb", 6'h00, 1'b1, e_wbr());
    cyc("lw_fetch_w0", 6'h23, 1'b0, e_fetch(1'b0));
    cyc("lw_fetch_w1", 6'h23, 1'b0, e_fetch(1'b0));
    cyc("lw_fetch", 6'h23, 1'b1, e_fetch(1'b1));
    cyc("lw_decode", 6'h23, 1'b1, e_dec(1'b0));
    cyc("lw_addr", 6'h23, 1'b1, e_madr());
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 6'h23, 1'b0, e_mrd());
    cyc("lw_rd", 6'h23, 1'b1, e_mrd());
    cyc("lw_wb", 6'h23, 1'b1, e_mwb());
    cyc("bne_fetch", 6'h05, 1'b1, e_fetch(1'b1));
    cyc("bne_decode", 6'h05, 1'b1, e_dec(1'b0));
    cyc("bne_branch", 6'h05, 1'b1, e_br(1'b1));
    cyc("beq_fetch", 6'h04, 1'b1, e_fetch(1'b1));
    cyc("beq_decode", 6'h04, 1'b1, e_dec(1'b0));
    cyc("beq_branch", 6'h04, 1'b1, e_br(1'b0));
    cyc("ori_fetch", 6'h0d, 1'b1, e_fetch(1'b1));
    cyc("ori_decode", 6'h0d, 1'b1, e_dec(1'b0));
    cyc("ori_exec", 6'h0d, 1'b1, e_exi(3'b100));
    cyc("ori_wb", 6'h0d, 1'b1, e_wbi());
    cyc("lui_fetch", 6'h0f, 1'b1, e_fetch(1'b1));
    cyc("lui_decode", 6'h0f, 1'b1, e_dec(1'b0));
    cyc("lui_exec", 6'h0f, 1'b1, e_exi(3'b101));
    cyc("lui_wb", 6'h0f, 1'b1, e_wbi());
    cyc("addi_fetch", 6'h08, 1'b1, e_fetch(1'b1));
    cyc("addi_decode", 6'h08, 1'b1, e_dec(1'b0));
    cyc("addi_exec", 6'h08, 1'b1, e_exi(3'b000));
    cyc("addi_wb", 6'h08, 1'b1, e_wbi());
    cyc("j_fetch", 6'h02, 1'b1, e_fetch(1'b1));
    cyc("j_decode", 6'h02, 1'b1, e_dec(1'b0));
    cyc("j_jump", 6'h02, 1'b1, e_jmp());
    cyc("ill_fetch", 6'h3f, 1'b1, e_fetch(1'b1));
    cyc("ill_decode", 6'h3f, 1'b1, e_dec(1'b1));
    cyc("sw0_fetch", 6'h2b, 1'b1, e_fetch(1'b1));
    cyc("sw0_decode", 6'h2b, 1'b1, e_dec(1'b0));
    cyc("sw0_addr", 6'h2b, 1'b1, e_madr());
    cyc("sw0_wr", 6'h2b, 1'b1, e_mwr());
    cyc("sw_fetch", 6'h2b, 1'b1, e_fetch(1'b1));
    cyc("sw_decode", 6'h2b, 1'b1, e_dec(1'b0));
    cyc("sw_addr", 6'h2b, 1'b1, e_madr());
    cyc("sw_wr_wait", 6'h2b, 1'b0, e_mwr());
    // mid-cycle asynchronous reset while still waiting in MEM_WR
    q_exp.push_back(e_rst());
    q_nm.push_back("async_reset_negedge");
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (mem_write_o !== 1'b0 || state_o !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_now: got mem_write=%b state=%0d, expected mem_write=0 state=0",
               mem_write_o, state_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cyc("post_reset_rst", 6'h00, 1'b1, e_rst());
    cyc("post_reset_fetch", 6'h00, 1'b1, e_fetch(1'b1));
    for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(posedge clk_i);
    if (q_exp.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It is the producer side of the 3-bit ALUOp interface consumed by the ALU controller. It sequences each instruction through fetch, decode, execute, memory and write-back states, drives every datapath enable and mux select, and stalls on a variable-latency unified memory through a ready handshake.

## Interface
Parameters:
- none. Opcode, ALUOp and state encodings are fixed constants in the shared package.

Ports:
- clk_i  in  1  system clock, rising-edge
- rst_i  in  1  asynchronous, active-low reset
- opcode_i  in  6  instr[31:26], taken from the instruction register
- mem_ready_i  in  1  memory has completed the current read or write this cycle
- ALUOp_o  out  3  000 add, 001 beq (sub), 010 R-type (funct), 011 bne, 100 ori, 101 lui
- alu_src_a_o  out  1  0 = PC, 1 = register A
- alu_src_b_o  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_write_o, pc_write_cond_o, branch_ne_o  out  1 each  PC update controls
- ir_write_o, mem_read_o, mem_write_o, iord_o  out  1 each  memory and IR controls; iord 1 = data address
- reg_write_o, reg_dst_o, mem_to_reg_o  out  1 each  register-file write controls
- illegal_o  out  1  one-cycle pulse on an unknown opcode
- state_o  out  4  current state, debug only

## Operation
- States: RST, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP.
- Outputs are a Moore decode of the state. The exceptions are ir_write_o and pc_write_o in FETCH, which are gated by mem_ready_i (Mealy). Any output not listed for a state is 0.
- RST: all outputs 0. Unconditional transition to FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=000, pc_src=00. When mem_ready_i=1: ir_write=1, pc_write=1, go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ALUOp=000 (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC_R
  - 0x08, 0x0d, 0x0f → EXEC_I
  - 0x23, 0x2b → MEM_ADDR
  - 0x04, 0x05 → BRANCH
  - 0x02 → JUMP
  - any other opcode → FETCH with illegal_o=1 for this cycle
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUOp=010 → WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ALUOp = 000 (addi), 100 (ori) or 101 (lui) → WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=000 → MEM_RD for 0x23, MEM_WR for 0x2b.
- MEM_RD: mem_read=1, iord=1. Stay until mem_ready_i=1, then → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write=1, iord=1. Stay until mem_ready_i=1, then → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_src=01. ALUOp=001 with branch_ne=0 for 0x04; ALUOp=011 with branch_ne=1 for 0x05 → FETCH.
- JUMP: pc_write=1, pc_src=10 → FETCH.
- opcode_i is sampled in DECODE, MEM_ADDR, EXEC_I and BRANCH. The IR does not change outside FETCH, so the value is stable across all of these states.

## Timing
- Reset: rst_i low forces state=RST immediately, asynchronously, from any state, including mid-wait in MEM_RD, MEM_WR or FETCH. Outputs go to 0 combinationally while in RST. After rst_i rises, the first clock edge moves to FETCH.
- Cycle counts with zero wait (mem_ready_i high on first request):
  - R-type 4, I-type 4, lw 5, sw 4, beq/bne 3, j 3.
  - Each low cycle of mem_ready_i in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_read_o and mem_write_o stay asserted and stable throughout a wait. They are never both 1.
- pc_write_o and ir_write_o are high for exactly one cycle per fetch.
- illegal_o is high for one cycle in DECODE. The next state is FETCH, so the PC has already advanced past the bad word.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - ALUOp constants matching the ALU controller's decode
  - alu_src_b and pc_src select constants
- Sub-module mc_out_decode: purely combinational, maps (state, opcode, mem_ready) to all control outputs. The top level keeps only the state register and the next-state logic.

## Test plan
- Reset, then R-type add (opcode 0x00), mem_ready_i tied high → states FETCH, DECODE, EXEC_R, WB_R; ALUOp=010 in EXEC_R; reg_write=1 and reg_dst=1 in cycle 4.
- lw (0x23) with mem_ready_i low for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total; ir_write pulses once; mem_to_reg=1 and reg_write=1 in MEM_WB.
- bne (0x05) → BRANCH shows ALUOp=011, branch_ne=1, pc_write_cond=1, pc_src=01; returns to FETCH after 3 cycles.
- ori (0x0d), then lui (0x0f) → EXEC_I shows ALUOp=100, then 101, with alu_src_b=10; WB_I shows reg_dst=0.
- Opcode 0x3f → illegal_o=1 for one DECODE cycle, next state FETCH, no reg_write or mem_write in any cycle.
- sw (0x2b) waiting in MEM_WR with mem_ready_i low; assert rst_i low asynchronously between clock edges → mem_write_o drops to 0 immediately and state_o=RST; after release, FETCH on the next edge.
